seq_1001_transmitter: RTL and testbench
=======================================

SEQ_1001_TRANSMITTER -- requirements
Module: seq_1001_transmitter

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1001: 4-bit pattern, transmitted MSB first.
REQ-002 SHALL have parameter CNT_W, default 8: width of the burst-count and sent-count fields.
REQ-003 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-005 SHALL have port start  input  1: request a burst; accepted only while ready=1.
REQ-006 SHALL have port count  input  CNT_W: number of patterns in the burst; sampled with start.
REQ-007 SHALL have port overlap  input  1: overlapped-framing select; sampled with start.
REQ-008 SHALL have port tick  input  1: bit-rate enable; one bit emitted per sampled tick.
REQ-009 SHALL have port ready  output  1: high only in IDLE.
REQ-010 SHALL have port busy  output  1: high in SEND.
REQ-011 SHALL have port dout  output  1: serial data, registered, held between emitted bits.
REQ-012 SHALL have port dout_valid  output  1: one-cycle pulse per emitted bit.
REQ-013 SHALL have port frame_end  output  1: one-cycle pulse coincident with the last bit of each pattern.
REQ-014 SHALL have port done  output  1: one-cycle pulse at burst completion.
REQ-015 SHALL have port sent_cnt  output  CNT_W: patterns completed in the current or last burst.

Function
REQ-016 SHALL implement the states IDLE, SEND and DONE.
REQ-017 IDLE: on start=1, SHALL latch count and overlap, clear sent_cnt and bit index, then go to SEND; if count=0, SHALL go to DONE instead.
REQ-018 SEND: on each edge with tick=1, SHALL register the next pattern bit into dout and set dout_valid=1; otherwise dout_valid=0 and dout holds.
REQ-019 SHALL send all 4 bits (index 3..0) for the first pattern in a burst.
REQ-020 With overlap=1 and PATTERN[3]==PATTERN[0], SHALL send only bits 2..0 for each subsequent pattern, since the shared bit is already on the line; total bits = 3N+1.
REQ-021 With overlap=0, or when PATTERN[3]!=PATTERN[0], SHALL send all 4 bits per pattern; total bits = 4N.
REQ-022 SHALL assert frame_end and increment sent_cnt on the same edge that emits bit 0 of a pattern.
REQ-023 On emitting bit 0 of pattern N, SHALL go to DONE.
REQ-024 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 SHALL hold sent_cnt until the next accepted start.
REQ-026 SHALL ignore start while busy=1 or in DONE; the latched count and overlap SHALL be unaffected.
REQ-027 Input changes on count and overlap during SEND SHALL have no effect.
REQ-028 count=2^CNT_W-1 SHALL complete without wrap, with sent_cnt ending at 2^CNT_W-1.
REQ-029 Start and tick in the same IDLE cycle SHALL NOT emit a bit; the first bit needs a tick sampled in SEND.
REQ-030 tick in IDLE or DONE SHALL be ignored.

Reset
REQ-031 On a clock edge with reset=0, SHALL enter IDLE and set dout=0, dout_valid=0, frame_end=0, done=0, busy=0, sent_cnt=0, and clear the latched count, overlap and bit index.
REQ-032 Reset SHALL take priority over start and tick, including mid-burst; the first cycle after reset release SHALL show ready=1 with no residual pulses.

Verification
REQ-033 count=1, overlap=0, tick=1 continuously -> dout_valid on 4 consecutive cycles, dout=1,0,0,1, frame_end on the 4th, done the next cycle, sent_cnt=1.
REQ-034 count=2, overlap=1, tick=1 -> 7 bits 1,0,0,1,0,0,1, frame_end on bits 4 and 7, sent_cnt=2, done once.
REQ-035 count=2, overlap=0, tick high every 3rd cycle -> 8 bits spaced 3 cycles apart, dout held between them, dout_valid never on consecutive cycles.
REQ-036 count=0 with start -> done pulses within 1 cycle, no dout_valid, sent_cnt=0, ready=1 the cycle after.
REQ-037 reset=0 after bit 2 of a count=3 burst -> next edge all outputs 0, ready=1; a new start then sends a full burst from bit 3 of pattern 1.
REQ-038 start pulsed during SEND with a different count -> ignored; the original burst length is preserved.

Source files
------------

// File: rtl/seq_1001_transmitter.sv
// Serial pattern transmitter: sends a burst of `count` copies of PATTERN, MSB first, one bit per tick.
// With overlap, the shared end/start bit is sent once between back-to-back patterns.
module seq_1001_transmitter #(
    parameter logic [3:0] PATTERN = 4'b1001,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             overlap,
    input  logic             tick,
    output logic             ready,
    output logic             busy,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_end,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic             SHARED  = (PATTERN[3] == PATTERN[0]);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count_lat;
    logic             overlap_lat;
    logic [1:0]       bit_idx;

    // done is raised as DONE hands back to IDLE, so it follows the last frame_end by one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_end   <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
            count_lat   <= '0;
            overlap_lat <= 1'b0;
            bit_idx     <= 2'd0;
        end else begin
            dout_valid <= 1'b0;
            frame_end  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count_lat   <= count;
                        overlap_lat <= overlap;
                        sent_cnt    <= '0;
                        bit_idx     <= 2'd3;
                        ready       <= 1'b0;
                        if (count == '0) begin
                            state <= DONE;
                        end else begin
                            state <= SEND;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (tick) begin
                        dout       <= PATTERN[bit_idx];
                        dout_valid <= 1'b1;
                        if (bit_idx == 2'd0) begin
                            frame_end <= 1'b1;
                            sent_cnt  <= sent_cnt + CNT_ONE;
                            bit_idx   <= (overlap_lat && SHARED) ? 2'd2 : 2'd3;
                            if (sent_cnt == count_lat - CNT_ONE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx - 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_1001_transmitter.sv
// Randomized bench for seq_1001_transmitter; expected bit streams are built from the pattern/count/overlap rules.
module tb_seq_1001_transmitter;

    localparam int         CNT_W   = 8;
    localparam logic [3:0] PATTERN = 4'b1001;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             overlap = 1'b0;
    logic             tick = 1'b0;
    logic             ready, busy, dout, dout_valid, frame_end, done;
    logic [CNT_W-1:0] sent_cnt;

    int   checkCount = 0;
    int   passCount = 0;
    logic model_dout = 1'b0;

    seq_1001_transmitter #(.PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .overlap(overlap), .tick(tick),
        .ready(ready), .busy(busy), .dout(dout), .dout_valid(dout_valid),
        .frame_end(frame_end), .done(done), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    endtask

    task automatic checkIdle(input string tag, input int expSent);
        checkOutput({tag, "_ready"}, int'(ready), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_valid"}, int'(dout_valid), 0);
        checkOutput({tag, "_frame_end"}, int'(frame_end), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_sent_cnt"}, int'(sent_cnt), expSent);
    endtask

    // tickMode: 0 = always, 1 = every 3rd cycle, 2 = random
    task automatic applyStimulus(input int cnt, input bit ov, input int tickMode);
        bit   bits[$];
        bit   fes[$];
        int   cyc = 0;
        int   sentExp = 0;
        int   budget = 16 * cnt + 40;
        bit   tickPrev = 1'b0;
        bit   expValid, expFe;

        for (int p = 0; p < cnt; p++) begin
            int firstBit = (p == 0 || !(ov && PATTERN[3] == PATTERN[0])) ? 3 : 2;
            for (int i = firstBit; i >= 0; i--) begin
                bits.push_back(PATTERN[i]);
                fes.push_back(i == 0);
            end
        end

        @(negedge clk);
        checkOutput("ready_before_start", int'(ready), 1);
        start   = 1'b1;
        count   = CNT_W'(cnt);
        overlap = ov;
        tick    = 1'($urandom);

        if (cnt == 0) begin
            @(negedge clk);
            checkOutput("zero_done_early", int'(done), 0);
            checkOutput("zero_ready_in_done", int'(ready), 0);
            checkOutput("zero_valid", int'(dout_valid), 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("zero_done", int'(done), 1);
            checkOutput("zero_ready", int'(ready), 1);
            checkOutput("zero_valid2", int'(dout_valid), 0);
            checkOutput("zero_sent_cnt", int'(sent_cnt), 0);
            @(negedge clk);
            checkIdle("zero_after", 0);
            return;
        end

        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                checkOutput("timeout", 0, 1);
                break;
            end
            expValid = tickPrev && (bits.size() > 0);
            expFe = 1'b0;
            checkOutput("dout_valid", int'(dout_valid), int'(expValid));
            if (expValid) begin
                model_dout = bits.pop_front();
                expFe = fes.pop_front();
                if (expFe) sentExp++;
            end
            checkOutput("dout", int'(dout), int'(model_dout));
            checkOutput("frame_end", int'(frame_end), int'(expFe));
            checkOutput("sent_cnt", int'(sent_cnt), sentExp);
            checkOutput("done_early", int'(done), 0);
            checkOutput("ready_busy", int'(ready), 0);
            checkOutput("busy", int'(busy), int'(bits.size() > 0));
            if (bits.size() == 0) begin
                // DONE cycle: start and tick here must be ignored
                start = 1'b1;
                count = CNT_W'($urandom);
                tick  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                tick  = 1'b0;
                checkOutput("done", int'(done), 1);
                checkOutput("done_ready", int'(ready), 1);
                checkOutput("done_busy", int'(busy), 0);
                checkOutput("done_valid", int'(dout_valid), 0);
                checkOutput("done_frame_end", int'(frame_end), 0);
                checkOutput("done_sent_cnt", int'(sent_cnt), cnt);
                checkOutput("done_dout_hold", int'(dout), int'(model_dout));
                @(negedge clk);
                checkIdle("post_done", cnt);
                break;
            end
            case (tickMode)
                0:       tick = 1'b1;
                1:       tick = (cyc % 3 == 0);
                default: tick = 1'($urandom);
            endcase
            tickPrev = tick;
            start   = ($urandom % 4 == 0);
            count   = CNT_W'($urandom);
            overlap = 1'($urandom);
        end
        start = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic resetMidBurst();
        @(negedge clk);
        start = 1'b1; count = CNT_W'(3); overlap = 1'b0; tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rst_no_bit_yet", int'(dout_valid), 0);
        @(negedge clk);
        checkOutput("rst_bit3", int'(dout), int'(PATTERN[3]));
        @(negedge clk);
        checkOutput("rst_bit2_valid", int'(dout_valid), 1);
        checkOutput("rst_bit2", int'(dout), int'(PATTERN[2]));
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checkIdle("rst_mid", 0);
        checkOutput("rst_mid_dout", int'(dout), 0);
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        checkIdle("rst_release", 0);
        model_dout = 1'b0;
    endtask

    initial begin
        $display("[TB] starting seq_1001_transmitter bench");
        reset = 1'b0;
        tick  = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkIdle("reset", 0);
        checkOutput("reset_dout", int'(dout), 0);
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        checkIdle("after_reset", 0);

        applyStimulus(1, 1'b0, 0);
        applyStimulus(2, 1'b1, 0);
        applyStimulus(2, 1'b0, 1);
        applyStimulus(0, 1'b0, 0);
        applyStimulus(3, 1'b1, 2);
        resetMidBurst();
        applyStimulus(3, 1'b0, 0);
        for (int n = 0; n < 6; n++)
            applyStimulus($urandom_range(1, 6), 1'($urandom), $urandom_range(0, 2));
        applyStimulus(255, 1'b0, 0);
        applyStimulus(255, 1'b1, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
